// File: rtl/zmod_adc_spi_arbiter.sv
// Two-requester arbiter in front of the AD9648 SPI configuration master.
// Serialises commands, issues one start per command and returns ack/rdata/timeout.
module zmod_adc_spi_arbiter #(
    parameter int P_PRIORITY_MODE = 0,
    parameter int P_START_TIMEOUT = 16,
    parameter int P_GAP           = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [23:0] i24_cmd0,
    input  logic [23:0] i24_cmd1,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic [7:0]  o8_rdata0,
    output logic [7:0]  o8_rdata1,
    output logic        o_timeout,
    output logic [1:0]  o2_grant,
    output logic        o_spi_start,
    output logic [23:0] o24_spi_cmd,
    input  logic        i_spi_busy,
    input  logic [7:0]  i8_spi_rdata
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    localparam logic [7:0] TO_LAST  = 8'(P_START_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = 8'(P_GAP - 1);

    state_t     state, state_nx;
    logic [7:0] cnt;
    logic       owner;
    logic       last;
    logic       any_req, pick1;
    logic       start_d, done_d, timeout_d, cnt_run;

    assign any_req = i_req0 | i_req1;

    // On a round-robin tie the requester not served last wins.
    always_comb begin
        if (P_PRIORITY_MODE != 0) pick1 = ~i_req0;
        else                      pick1 = i_req1 & (~i_req0 | ~last);
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (any_req) state_nx = ISSUE;
            ISSUE:     state_nx = WAIT_BUSY;
            WAIT_BUSY: begin
                if (i_spi_busy)          state_nx = WAIT_DONE;
                else if (cnt == TO_LAST) state_nx = GAP;
            end
            WAIT_DONE: if (!i_spi_busy) state_nx = GAP;
            GAP:       if (cnt == GAP_LAST) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_d   = (state == ISSUE);
        timeout_d = (state == WAIT_BUSY) && !i_spi_busy && (cnt == TO_LAST);
        done_d    = timeout_d || ((state == WAIT_DONE) && !i_spi_busy);
        cnt_run   = (state_nx == state) && ((state == WAIT_BUSY) || (state == GAP));
    end

    // One counter serves both the start timeout and the gap; it clears on every state change.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt         <= 8'd0;
            owner       <= 1'b0;
            last        <= 1'b1;
            o_ack0      <= 1'b0;
            o_ack1      <= 1'b0;
            o_timeout   <= 1'b0;
            o_spi_start <= 1'b0;
            o2_grant    <= 2'b00;
            o24_spi_cmd <= 24'd0;
            o8_rdata0   <= 8'd0;
            o8_rdata1   <= 8'd0;
        end else begin
            cnt         <= cnt_run ? cnt + 8'd1 : 8'd0;
            o_spi_start <= start_d;
            o_timeout   <= timeout_d;
            o_ack0      <= done_d & ~owner;
            o_ack1      <= done_d & owner;
            if (state == IDLE && any_req) begin
                owner       <= pick1;
                o2_grant    <= pick1 ? 2'b10 : 2'b01;
                o24_spi_cmd <= pick1 ? i24_cmd1 : i24_cmd0;
            end
            if (done_d) begin
                o2_grant <= 2'b00;
                last     <= owner;
                if (!timeout_d && o24_spi_cmd[23]) begin
                    if (owner) o8_rdata1 <= i8_spi_rdata;
                    else       o8_rdata0 <= i8_spi_rdata;
                end
            end
        end
    end

endmodule
